// File: rtl/membus_arbiter_pkg.sv
// Shared definitions for the two-port memory-bus arbiter: state encoding,
// bus widths and the wait-state counter bounds.
package membus_arbiter_pkg;

  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int READ_LATENCY_MAX = 7;
  localparam int CNT_W            = 3;

  localparam logic [CNT_W-1:0] CNT_ONE = 3'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_e;

endpackage

// File: rtl/membus_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the pointer moves to the other port whenever a
// grant is accepted, so a lone requester is served regardless of the pointer.
module membus_arbiter_rr_arbiter2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       valid_o,
  output logic       grant_idx_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection: contention resolved by the pointer
  always_comb begin
    valid_o = req_i[0] | req_i[1];
    if (req_i[0] && req_i[1]) begin
      grant_idx_o = ptr_q;
    end else if (req_i[1]) begin
      grant_idx_o = 1'b1;
    end else begin
      grant_idx_o = 1'b0;
    end
  end

  // Pointer next-state
  always_comb begin
    if (accept_i && valid_o) begin
      ptr_d = ~grant_idx_o;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// Two-port memory-bus arbiter: serialises CPU and secondary-master accesses to
// the device bus with one-cycle strobes, optional read wait states and acks.
module membus_arbiter
  import membus_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 0,
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int DATA_WIDTH   = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  Device_Read,
  output logic                  Device_Write,
  output logic [ADDR_WIDTH-1:0] MemBus_Address,
  output logic [DATA_WIDTH-1:0] MemBus_Write_Data,
  input  logic [DATA_WIDTH-1:0] Device_Read_Data,
  output logic                  busy
);

  // READ_LATENCY must stay within 0..READ_LATENCY_MAX to fit the counter.
  localparam logic [CNT_W-1:0] LOAD_CNT  = CNT_W'(READ_LATENCY);
  localparam bit               ZERO_WAIT = (READ_LATENCY == 0);

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic                  busy_q, busy_d;

  logic idle_s, arb_valid_s, arb_idx_s, grant_s, capture_s, sel_we_s;

  assign idle_s  = (state_q == IDLE);
  assign grant_s = idle_s & arb_valid_s;

  membus_arbiter_rr_arbiter2 u_arb (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       ({req1, req0}),
    .accept_i    (idle_s),
    .valid_o     (arb_valid_s),
    .grant_idx_o (arb_idx_s)
  );

  // Read data is sampled in the strobe cycle or in the last wait cycle
  always_comb begin
    if (state_q == ACCESS) begin
      capture_s = ~we_q & ZERO_WAIT;
    end else if (state_q == WAIT) begin
      capture_s = (cnt_q == CNT_ONE);
    end else begin
      capture_s = 1'b0;
    end
  end

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (we_q || ZERO_WAIT) begin
          state_d = ACK;
        end else begin
          state_d = WAIT;
          cnt_d   = LOAD_CNT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ACK;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered bus, strobe, ack and read-data outputs
  always_comb begin
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sel_we_s = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    if (grant_s) begin
      if (arb_idx_s) begin
        sel_we_s = we1;
        addr_d   = addr1;
        wdata_d  = wdata1;
      end else begin
        sel_we_s = we0;
        addr_d   = addr0;
        wdata_d  = wdata0;
      end
      gnt_d = arb_idx_s;
      we_d  = sel_we_s;
      rd_d  = ~sel_we_s;
      wr_d  = sel_we_s;
    end else begin
      rd_d = 1'b0;
      wr_d = 1'b0;
    end
    if (capture_s) begin
      if (gnt_q) begin
        rdata1_d = Device_Read_Data;
      end else begin
        rdata0_d = Device_Read_Data;
      end
    end else begin
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
    end
    if (state_d == ACK) begin
      ack0_d = ~gnt_q;
      ack1_d = gnt_q;
    end else begin
      ack0_d = 1'b0;
      ack1_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  assign ack0              = ack0_q;
  assign ack1              = ack1_q;
  assign rdata0            = rdata0_q;
  assign rdata1            = rdata1_q;
  assign Device_Read       = rd_q;
  assign Device_Write      = wr_q;
  assign MemBus_Address    = addr_q;
  assign MemBus_Write_Data = wdata_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: a zero-wait instance driven from a vector table
// and contention/withdrawal sequences, plus a three-wait-state instance.
module tb_membus_arbiter;

  typedef struct {
    bit          port;
    bit          is_read;
    logic [31:0] rdata;
    int          ack_cyc;
  } sb_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dev;
  } vec_t;

  logic        clk;
  logic        rst, req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1, dev0;
  logic        ack0, ack1, drd, dwr, busy;
  logic [31:0] rdata0, rdata1, maddr, mwdata;

  logic        rst3, req0_3, we0_3, req1_3, we1_3;
  logic [31:0] addr0_3, wdata0_3, addr1_3, wdata1_3, dev3;
  logic        ack0_3, ack1_3, drd3, dwr3, busy3;
  logic [31:0] rdata0_3, rdata1_3, maddr3, mwdata3;
  logic [2:0]  sr3;

  membus_arbiter #(.READ_LATENCY(0)) dut (
    .clk(clk), .reset(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .Device_Read(drd), .Device_Write(dwr), .MemBus_Address(maddr),
    .MemBus_Write_Data(mwdata), .Device_Read_Data(dev0), .busy(busy)
  );

  membus_arbiter #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(rst3),
    .req0(req0_3), .we0(we0_3), .addr0(addr0_3), .wdata0(wdata0_3), .ack0(ack0_3), .rdata0(rdata0_3),
    .req1(req1_3), .we1(we1_3), .addr1(addr1_3), .wdata1(wdata1_3), .ack1(ack1_3), .rdata1(rdata1_3),
    .Device_Read(drd3), .Device_Write(dwr3), .MemBus_Address(maddr3),
    .MemBus_Write_Data(mwdata3), .Device_Read_Data(dev3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slow device: good data only in the third cycle after a read strobe
  always @(posedge clk) begin
    if (rst3) sr3 <= 3'd0;
    else      sr3 <= {sr3[1:0], drd3};
  end
  assign dev3 = sr3[2] ? 32'h12345678 : 32'hBAD0BAD0;

  sb_t         sb[$];
  vec_t        vecs[5];
  logic [31:0] rdm[2];
  logic [31:0] last_addr, last_wdata;
  int          checks = 0, errors = 0, cyc = 0;
  int          rd_cnt = 0, wr_cnt = 0, ack1_cnt = 0;
  bit          cont_mode = 1'b0, prev_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic mon();
    sb_t e;
    if (drd || dwr) begin
      chk("no_overlap", {31'd0, drd & dwr}, 32'd0);
      if (drd) rd_cnt++;
      if (dwr) wr_cnt++;
      last_addr  = maddr;
      last_wdata = mwdata;
    end
    if (cont_mode && !busy) chk("busy_gap", {31'd0, prev_ack}, 32'd1);
    if (ack1) ack1_cnt++;
    if (ack0 || ack1) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", {30'd0, ack1, ack0}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_port", {30'd0, ack1, ack0}, e.port ? 32'd2 : 32'd1);
        chk("ack_cycle", cyc, e.ack_cyc);
        if (e.is_read) chk("ack_rdata", e.port ? rdata1 : rdata0, e.rdata);
      end
    end
    prev_ack = ack0 | ack1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    mon();
  endtask

  task automatic push_exp(input bit port, input bit is_read, input logic [31:0] rd, input int ack_cyc);
    sb_t e;
    e.port = port; e.is_read = is_read; e.rdata = rd; e.ack_cyc = ack_cyc;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    int rd0, wr0, n;
    bit got;
    rd0 = rd_cnt; wr0 = wr_cnt;
    dev0 = v.dev;
    push_exp(v.port, ~v.we, v.dev, cyc + 2);
    if (v.port) begin req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
    else        begin req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      step();
      n++;
      got = v.port ? ack1 : ack0;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("vec_ack_seen", {31'd0, got}, 32'd1);
    if (!got) sb.delete();
    chk("vec_rd_strobes", rd_cnt - rd0, {31'd0, ~v.we});
    chk("vec_wr_strobes", wr_cnt - wr0, {31'd0, v.we});
    chk("vec_addr", last_addr, v.addr);
    if (v.we) chk("vec_wdata", last_wdata, v.wdata);
    else      rdm[v.port] = v.dev;
    chk("vec_rdata0", rdata0, rdm[0]);
    chk("vec_rdata1", rdata1, rdm[1]);
    step();
    chk("vec_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_zero3(input string tag);
    chk({tag, "_ctrl"}, {27'd0, ack0_3, ack1_3, drd3, dwr3, busy3}, 32'd0);
    chk({tag, "_addr"}, maddr3, 32'd0);
    chk({tag, "_wdata"}, mwdata3, 32'd0);
    chk({tag, "_rdata0"}, rdata0_3, 32'd0);
    chk({tag, "_rdata1"}, rdata1_3, 32'd0);
  endtask

  initial begin
    int c0, n, nack, rd0, wr0, a1;
    bit got, first;
    logic [31:0] first_addr;

    rst = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0; dev0 = 32'd0;
    rst3 = 1'b1; req0_3 = 1'b0; we0_3 = 1'b0; addr0_3 = 32'd0; wdata0_3 = 32'd0;
    req1_3 = 1'b0; we1_3 = 1'b0; addr1_3 = 32'd0; wdata1_3 = 32'd0;
    rdm[0] = 32'd0; rdm[1] = 32'd0;
    last_addr = 32'd0; last_wdata = 32'd0;

    vecs[0] = '{1'b0, 1'b0, 32'h40000010, 32'h00000000, 32'h0000ABCD};
    vecs[1] = '{1'b1, 1'b1, 32'h40000018, 32'h00000041, 32'h77777777};
    vecs[2] = '{1'b1, 1'b0, 32'h40000020, 32'h00000000, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b1, 32'h40000008, 32'hFFFFFFFF, 32'h00000000};
    vecs[4] = '{1'b0, 1'b0, 32'h4000000C, 32'h00000000, 32'h00000000};

    repeat (3) step();
    chk("rst_ctrl", {27'd0, ack0, ack1, drd, dwr, busy}, 32'd0);
    chk("rst_addr", maddr, 32'd0);
    chk("rst_wdata", mwdata, 32'd0);
    chk("rst_rdata", rdata0 | rdata1, 32'd0);
    chk_zero3("rst3");
    rst = 1'b0; rst3 = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Port 1 pulses req for one cycle while port 0 is in ACCESS
    a1 = ack1_cnt; rd0 = rd_cnt;
    dev0 = 32'h11112222;
    push_exp(1'b0, 1'b1, 32'h11112222, cyc + 2);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40000030;
    step();
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40000034;
    step();
    req1 = 1'b0; req0 = 1'b0;
    repeat (5) step();
    rdm[0] = 32'h11112222;
    chk("wd_no_ack1", ack1_cnt - a1, 32'd0);
    chk("wd_one_read", rd_cnt - rd0, 32'd1);
    chk("wd_sb_empty", sb.size(), 32'd0);
    chk("wd_busy", {31'd0, busy}, 32'd0);
    sb.delete();

    // Continuous contention starting straight out of reset
    rst = 1'b1;
    step();
    rdm[0] = 32'd0; rdm[1] = 32'd0;
    dev0 = 32'h5A5A0001;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40000050; wdata0 = 32'h000000A0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40000054; wdata1 = 32'd0;
    step();
    rd0 = rd_cnt; wr0 = wr_cnt;
    rst = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 6; k++) push_exp(k[0], k[0], 32'h5A5A0001, c0 + 2 + 3 * k);
    cont_mode = 1'b1;
    nack = 0; n = 0;
    while (nack < 6 && n < 40) begin
      step();
      n++;
      if (ack0 || ack1) nack++;
    end
    cont_mode = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_acks", nack, 32'd6);
    chk("cont_reads", rd_cnt - rd0, 32'd3);
    chk("cont_writes", wr_cnt - wr0, 32'd3);
    chk("cont_sb_empty", sb.size(), 32'd0);
    sb.delete();
    step();
    chk("cont_busy", {31'd0, busy}, 32'd0);
    chk("cont_rdata0", rdata0, 32'd0);
    chk("cont_rdata1", rdata1, 32'h5A5A0001);

    // Three wait states: ack five cycles after request, strobe only in ACCESS
    req0_3 = 1'b1; we0_3 = 1'b0; addr0_3 = 32'h40000004;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("rl3_ack0", {31'd0, ack0_3}, {31'd0, k == 5});
      chk("rl3_strobe", {31'd0, drd3}, {31'd0, k == 1});
      if (k == 1) chk("rl3_addr", maddr3, 32'h40000004);
      if (k == 5) begin
        chk("rl3_rdata", rdata0_3, 32'h12345678);
        req0_3 = 1'b0;
      end
    end
    chk("rl3_busy", {31'd0, busy3}, 32'd0);

    // Reset while in WAIT
    req0_3 = 1'b1; we0_3 = 1'b0; addr0_3 = 32'h40000044;
    step();
    step();
    chk("mid_in_wait", {31'd0, busy3}, 32'd1);
    rst3 = 1'b1; req0_3 = 1'b0;
    step();
    chk_zero3("mid_rst");
    rst3 = 1'b0;
    nack = 0;
    repeat (8) begin
      step();
      if (ack0_3 || ack1_3) nack++;
    end
    chk("mid_never_acked", nack, 32'd0);

    // Pointer back at port 0 after reset
    req0_3 = 1'b1; we0_3 = 1'b0; addr0_3 = 32'h40000004;
    req1_3 = 1'b1; we1_3 = 1'b0; addr1_3 = 32'h40000024;
    got = 1'b0; first = 1'b1; first_addr = 32'd0; n = 0;
    while (!got && n < 20) begin
      step();
      n++;
      if (drd3 && first) begin first_addr = maddr3; first = 1'b0; end
      got = ack0_3 | ack1_3;
    end
    chk("ptr_first_ack", {30'd0, ack1_3, ack0_3}, 32'd1);
    chk("ptr_first_addr", first_addr, 32'h40000004);
    chk("ptr_first_lat", n, 32'd5);
    req0_3 = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      step();
      n++;
      got = ack1_3;
    end
    req1_3 = 1'b0;
    chk("ptr_second_ack1", {31'd0, got}, 32'd1);
    chk("ptr_rdata1", rdata1_3, 32'h12345678);
    step();
    chk("ptr_busy", {31'd0, busy3}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
